// File: rtl/alu_addsub_pipe_pkg.sv
// Shared op encoding for the pipelined add/sub/compare unit.
// Imported by the interface, the slice adder and the top.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_OP_ADD = 2'b00,
    ALU_OP_SUB = 2'b01,
    ALU_OP_CMP = 2'b10,
    ALU_OP_ILL = 2'b11
  } alu_op_e;

  function automatic logic is_sub(input alu_op_e op);
    return (op == ALU_OP_SUB) || (op == ALU_OP_CMP);
  endfunction

endpackage

// File: rtl/alu_addsub_pipe_if.sv
// Issue/writeback handshake bundle for alu_addsub_pipe.
// The slave modport is the unit's view; master is the issue/consumer side.
interface alu_addsub_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  alu_op_e          in_op;
  logic             in_sat;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic [TAG_W-1:0] out_tag;
  logic             out_v;
  logic             out_n;
  logic             out_z;
  logic             out_un_v;
  logic             out_un_n;
  logic             out_un_z;

  modport slave (
    input  in_valid, in_op, in_sat, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_s, out_tag,
    output out_v, out_n, out_z, out_un_v, out_un_n, out_un_z
  );

  modport master (
    output in_valid, in_op, in_sat, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_s, out_tag,
    input  out_v, out_n, out_z, out_un_v, out_un_n, out_un_z
  );

endinterface

// File: rtl/alu_addsub_slice.sv
// Combinational SW-bit slice adder; also reports the carry into
// its MSB so the top slice can derive signed overflow.
module alu_addsub_slice #(
  parameter int SW = 16
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          ci_i,
  output logic [SW-1:0] s_o,
  output logic          co_o,
  output logic          cm_o
);

  logic [SW-1:0] low;

  assign low  = {1'b0, a_i[SW-2:0]}
              + {1'b0, b_i[SW-2:0]}
              + {{(SW-1){1'b0}}, ci_i};
  assign cm_o = low[SW-1];
  assign s_o  = {a_i[SW-1] ^ b_i[SW-1] ^ cm_o, low[SW-2:0]};
  assign co_o = (a_i[SW-1] & b_i[SW-1])
              | (cm_o & (a_i[SW-1] ^ b_i[SW-1]));

endmodule

// File: rtl/alu_addsub_pipe.sv
// Pipelined add/sub/compare with valid/ready backpressure and tag passthrough.
// Define ALU_ADDSUB_SAT_EN to enable signed saturation on in_sat.
module alu_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input logic clk,
  input logic rst,
  alu_addsub_pipe_if.slave bus
);

  localparam int SW = WIDTH / STAGES;
  localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int L  = STAGES - 1;

  logic             vld_q [NR];
  logic [WIDTH-1:0] a_q   [NR];
  logic [WIDTH-1:0] bx_q  [NR];
  logic [WIDTH-1:0] s_q   [NR];
  logic             c_q   [NR];
  alu_op_e          op_q  [NR];
  logic             sat_q [NR];
  logic [TAG_W-1:0] tag_q [NR];

  logic             ov_q, v_q, n_q, z_q, uv_q, un_q;
  logic [WIDTH-1:0] os_q;
  logic [TAG_W-1:0] otag_q;

  // Per-stage inputs: stage 0 from the bus, stage k from register k-1
  logic             x_vld [STAGES];
  logic [WIDTH-1:0] x_a   [STAGES];
  logic [WIDTH-1:0] x_bx  [STAGES];
  logic [WIDTH-1:0] x_s   [STAGES];
  logic             x_ci  [STAGES];
  alu_op_e          x_op  [STAGES];
  logic             x_sat [STAGES];
  logic [TAG_W-1:0] x_tag [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];

  logic [STAGES-1:0][SW-1:0] sl_a, sl_b, sl_s;
  logic [STAGES-1:0]         sl_ci, sl_co;
  logic                      cm_top;

  logic [STAGES-1:0] stg_vld;
  logic [STAGES:0]   rdy;

  logic             v_d, n_d, z_d, uv_d, un_d, sat_hit;
  logic [WIDTH-1:0] os_d;

  always_comb begin : p_mux
    x_vld[0] = bus.in_valid;
    x_op[0]  = bus.in_op;
    x_sat[0] = bus.in_sat;
    x_tag[0] = bus.in_tag;
    x_a[0]   = bus.in_a;
    x_bx[0]  = is_sub(bus.in_op) ? ~bus.in_b : bus.in_b;
    x_s[0]   = '0;
    x_ci[0]  = is_sub(bus.in_op);
    for (int k = 1; k < STAGES; k++) begin
      x_vld[k] = vld_q[k-1];
      x_op[k]  = op_q[k-1];
      x_sat[k] = sat_q[k-1];
      x_tag[k] = tag_q[k-1];
      x_a[k]   = a_q[k-1];
      x_bx[k]  = bx_q[k-1];
      x_s[k]   = s_q[k-1];
      x_ci[k]  = c_q[k-1];
    end
  end

  always_comb begin : p_slice_in
    sl_a  = '0;
    sl_b  = '0;
    sl_ci = '0;
    for (int k = 0; k < STAGES; k++) begin
      sl_a[k]  = x_a[k][k*SW +: SW];
      sl_b[k]  = x_bx[k][k*SW +: SW];
      sl_ci[k] = x_ci[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_sl
    if (k == STAGES - 1) begin : g_top
      alu_addsub_slice #(.SW(SW)) u_slice (
        .a_i  (sl_a[k]),
        .b_i  (sl_b[k]),
        .ci_i (sl_ci[k]),
        .s_o  (sl_s[k]),
        .co_o (sl_co[k]),
        .cm_o (cm_top)
      );
    end else begin : g_low
      logic cm_unused;
      alu_addsub_slice #(.SW(SW)) u_slice (
        .a_i  (sl_a[k]),
        .b_i  (sl_b[k]),
        .ci_i (sl_ci[k]),
        .s_o  (sl_s[k]),
        .co_o (sl_co[k]),
        .cm_o (cm_unused)
      );
    end
  end

  always_comb begin : p_sum
    for (int k = 0; k < STAGES; k++) begin
      s_d[k] = x_s[k];
      s_d[k][k*SW +: SW] = sl_s[k];
    end
  end

  always_comb begin : p_rdy
    stg_vld = '0;
    for (int k = 0; k < STAGES - 1; k++) begin
      stg_vld[k] = vld_q[k];
    end
    stg_vld[L] = ov_q;
    rdy = '0;
    rdy[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~stg_vld[k] | rdy[k+1];
    end
  end

  // Overflow from carry-in vs carry-out of the top bit
  always_comb begin : p_flags
    v_d  = cm_top ^ sl_co[L];
    n_d  = s_d[L][WIDTH-1] ^ v_d;
    z_d  = ~|s_d[L];
    uv_d = is_sub(x_op[L]) ? ~sl_co[L] : sl_co[L];
    un_d = is_sub(x_op[L]) & ~sl_co[L];
    os_d = (x_op[L] == ALU_OP_CMP) ? '0 : s_d[L];
    if (sat_hit) begin
      os_d = n_d ? {1'b1, {(WIDTH-1){1'b0}}}
                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

`ifdef ALU_ADDSUB_SAT_EN
  assign sat_hit = x_sat[L] & v_d & (x_op[L] != ALU_OP_CMP);
`else
  logic sat_unused;
  assign sat_unused = x_sat[L];
  assign sat_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NR; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        op_q[k]  <= ALU_OP_ADD;
        sat_q[k] <= 1'b0;
        tag_q[k] <= '0;
      end
      ov_q   <= 1'b0;
      os_q   <= '0;
      otag_q <= '0;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
      uv_q   <= 1'b0;
      un_q   <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES - 1; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= x_vld[k];
          if (x_vld[k]) begin
            a_q[k]   <= x_a[k];
            bx_q[k]  <= x_bx[k];
            s_q[k]   <= s_d[k];
            c_q[k]   <= sl_co[k];
            op_q[k]  <= x_op[k];
            sat_q[k] <= x_sat[k];
            tag_q[k] <= x_tag[k];
          end
        end
      end
      if (rdy[L]) begin
        ov_q <= x_vld[L];
        if (x_vld[L]) begin
          os_q   <= os_d;
          otag_q <= x_tag[L];
          v_q    <= v_d;
          n_q    <= n_d;
          z_q    <= z_d;
          uv_q   <= uv_d;
          un_q   <= un_d;
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = ov_q;
  assign bus.out_s     = os_q;
  assign bus.out_tag   = otag_q;
  assign bus.out_v     = v_q;
  assign bus.out_n     = n_q;
  assign bus.out_z     = z_q;
  assign bus.out_un_v  = uv_q;
  assign bus.out_un_n  = un_q;
  assign bus.out_un_z  = z_q;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Scoreboard bench for alu_addsub_pipe (WIDTH=32, STAGES=2).
// Reference model works on signed/unsigned integer arithmetic.
module tb_alu_addsub_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_addsub_pipe_if #(.WIDTH(32), .TAG_W(4)) bus ();

  alu_addsub_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] s;
    logic [3:0]  tag;
    logic        v, n, z, uv, un, uz;
  } exp_t;

  exp_t exq[$];
  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;
  bit   rnd_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic sat,
                                 input logic [3:0] tag);
    exp_t   e;
    longint sa, sb, t, ua, ub;
    logic   sub;
    logic [31:0] w;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    sub = (op == 2'b01) || (op == 2'b10);
    t   = sub ? sa - sb : sa + sb;
    w   = sub ? a - b : a + b;
    e.v  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    e.n  = (t < 0);
    e.z  = (w == 32'd0);
    e.uz = e.z;
    e.uv = sub ? (a < b) : (ua + ub > 64'hFFFF_FFFF);
    e.un = sub && (a < b);
    e.s  = (op == 2'b10) ? 32'd0 : w;
    e.tag = tag;
`ifdef ALU_ADDSUB_SAT_EN
    if (sat && e.v && op != 2'b10)
      e.s = e.n ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    if (sat) e.s = e.s;
`endif
    return e;
  endfunction

  function automatic exp_t got();
    exp_t g;
    g.s = bus.out_s; g.tag = bus.out_tag;
    g.v = bus.out_v; g.n = bus.out_n; g.z = bus.out_z;
    g.uv = bus.out_un_v; g.un = bus.out_un_n; g.uz = bus.out_un_z;
    return g;
  endfunction

  // Monitor: every presented result is checked against the queue head
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=%h required=none", bus.out_s);
      end else begin
        chk("result", 64'(got()), 64'(exq[0]));
        if (bus.out_ready) void'(exq.pop_front());
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rnd_on) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic sat,
                      input logic [3:0] tag);
    bit acc = 1'b0;
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = alu_op_e'(op);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sat   = sat;
    bus.in_tag   = tag;
    while (!acc && guard < 500) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end else begin
      exq.push_back(model(op, a, b, sat, tag));
      n_acc++;
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int guard;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op = ALU_OP_ADD;
    bus.in_sat = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_s", 64'(bus.out_s), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_flags", 64'(got()), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Latency: acceptance cycle counts as cycle 1
    send(2'b00, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'h1);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd2);

    send(2'b01, 32'h0, 32'h1, 1'b0, 4'h2);
    send(2'b10, 32'h5, 32'h5, 1'b0, 4'h3);
    send(2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'hA);
    send(2'b01, 32'h8000_0000, 32'h1, 1'b0, 4'h4);
    send(2'b11, 32'h1234_5678, 32'h1111_1111, 1'b0, 4'h5);
    send(2'b00, 32'h7FFF_FFFF, 32'h1, 1'b1, 4'h6);
    send(2'b01, 32'h8000_0000, 32'h1, 1'b1, 4'h7);
    send(2'b10, 32'h8000_0000, 32'h1, 1'b1, 4'h8);
    repeat (4) @(posedge clk);
    #1;

    // Stall: consumer blocked for 4 cycles while 6 ops are offered
    n_acc = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(2'($urandom_range(0, 2)), rnd_val(), rnd_val(), 1'b0, 4'(i));
      end
      begin
        repeat (4) @(negedge clk);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_held", 64'(n_acc), 64'd2);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset with two ops in flight
    bus.out_ready = 1'b0;
    send(2'b00, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 4'hC);
    send(2'b01, 32'h0000_0010, 32'h0000_0001, 1'b0, 4'hD);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exq.delete();
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_s", 64'(bus.out_s), 64'd0);
    chk("mid_rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("mid_rst_flags", 64'(got()), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    rnd_on = 1'b1;
    for (int i = 0; i < 300; i++)
      send(2'($urandom_range(0, 3)), rnd_val(), rnd_val(),
           1'($urandom_range(0, 1)), 4'($urandom));
    rnd_on = 1'b0;
    bus.out_ready = 1'b1;

    guard = 0;
    while (exq.size() != 0 && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_left", 64'(exq.size()), 64'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_addsub_pipe.md
Name: alu_addsub_pipe

Overview:
- Parametrised, pipelined add/subtract/compare unit for the MIPS datapath; next generation of the fixed 32-bit combinational adder/subtractor.
- Splits the carry chain across STAGES register stages for timing closure.
- Carries a valid/ready handshake and a tag passthrough, so it can sit between the issue logic and writeback under backpressure.
- Produces signed flags (V, N, Z) and unsigned flags (UN_V, UN_N, UN_Z).

Parameters:
- WIDTH, 32: operand and result width; must be a multiple of STAGES.
- STAGES, 2: pipeline depth, 1..4; each stage adds WIDTH/STAGES bits.
- TAG_W, 4: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  2  ALU_OP_ADD / ALU_OP_SUB / ALU_OP_CMP.
- in_sat  in  1  saturate signed result (see Optional Feature).
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_s  out  WIDTH  result.
- out_tag  out  TAG_W  tag of this result.
- out_v, out_n, out_z  out  1 each  signed overflow, signed less-than/negative, zero.
- out_un_v, out_un_n, out_un_z  out  1 each  unsigned carry/borrow, unsigned less-than, zero.

Behaviour:
- Reset: rst high at a clock edge clears every stage valid bit and zeroes all data and flag registers. After reset: out_valid=0, out_s=0, out_tag=0, all flags 0, in_ready=1. A reset mid-operation discards all in-flight operations; no partial result emerges.
- Accepting an operation: an operation is accepted when in_valid && in_ready.
- Per-stage handshake: each stage k holds a valid bit. Stage k advances when !valid_k or ready_{k+1}; ready at the output equals out_ready. in_ready = ready into stage 0, computed combinationally from the chain.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 op/cycle.
- Stall: while out_valid && !out_ready, out_s, out_tag and all flags hold stable. Older stages fill up, then in_ready drops. No loss, no duplication, order preserved.
- Operand formation:
  - ADD: a + b, carry-in 0.
  - SUB and CMP: a + ~b, carry-in 1.
  - Stage k sums slice k of the operands plus the carry from stage k-1. Low slices are registered forward; upper operand slices are delayed until consumed.
- Result: for CMP, out_s=0 but all flags are computed from the true difference.
- Flags, computed from the final sum d (WIDTH bits) and the final carry c:
  - V = (a[MSB]==b'[MSB]) && (d[MSB]!=a[MSB]), where b' is b for ADD and ~b for SUB/CMP.
  - N = d[MSB] ^ V, i.e. the true sign; for SUB/CMP this is signed a<b.
  - Z = (d==0).
  - UN_V = c for ADD; ~c (borrow) for SUB/CMP.
  - UN_N = 0 for ADD; ~c for SUB/CMP (unsigned a<b).
  - UN_Z = Z.
- Illegal op 2'b11: treated as ADD.
- Wrap-around: without saturation, results wrap modulo 2^WIDTH.

Optional Feature:
- Macro: ALU_ADDSUB_SAT_EN.
- Defined: when in_sat=1 and V=1 on ADD/SUB, out_s is clamped to the signed limit.
  - Most-positive value (0x7FFF_FFFF for WIDTH 32) if the true result is positive.
  - Most-negative value (0x8000_0000) if it is negative.
  - Flags are unaffected; V still reports 1.
  - The clamp is applied in the final stage; latency is unchanged.
- Undefined: in_sat is ignored and results always wrap.

Decomposition:
- Package alu_pkg: ALU_OP_ADD=2'b00, ALU_OP_SUB=2'b01, ALU_OP_CMP=2'b10, and the op typedef.
- Sub-module alu_addsub_slice: combinational slice adder.
  - Inputs: a-slice, b-slice, carry-in.
  - Outputs: sum slice, carry-out, carry into the slice MSB (for V).
  - Instantiated STAGES times.

Test Plan (WIDTH=32, STAGES=2):
- ADD a=0x7FFFFFFF, b=1 -> out_s=0x80000000, V=1, N=0, Z=0, UN_V=0, UN_N=0, out_valid exactly 2 cycles after acceptance.
- SUB a=0, b=1 -> out_s=0xFFFFFFFF, V=0, N=1, UN_V=1, UN_N=1, Z=0. CMP a=5, b=5 -> out_s=0, Z=1, UN_Z=1, UN_V=0.
- ADD a=0xFFFFFFFF, b=1, tag=0xA -> out_s=0, Z=1, UN_V=1, out_tag=0xA. SUB a=0x80000000, b=1 -> out_s=0x7FFFFFFF, V=1, N=1.
- Send 6 back-to-back ops while out_ready=0 for 4 cycles -> in_ready falls after 2 ops are held. out_s and flags stay stable under stall. All 6 results emerge in order, matching a reference model.
- Assert rst for 1 cycle with 2 ops in flight -> next cycle out_valid=0, all outputs 0, in_ready=1. Neither op ever appears on the output.
- With ALU_ADDSUB_SAT_EN, in_sat=1: ADD 0x7FFFFFFF+1 -> out_s=0x7FFFFFFF, V=1. SUB 0x80000000-1 -> out_s=0x80000000. Without the macro, the same stimulus wraps.
